io_write_buffer: RTL and testbench
==================================

IO_WRITE_BUFFER -- requirements
Module: io_write_buffer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36: width of the I/O word.
REQ-002 SHALL have parameter DEPTH, default 8: number of FIFO entries; a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3: equals log2(DEPTH); WORD_WIDTH SHALL be at least ADDR_WIDTH+4.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port io_wren, input, 1 bit: write strobe from one scalar write I/O port.
REQ-007 SHALL have port io_in, input, WORD_WIDTH bits: write data from the same write I/O port.
REQ-008 SHALL have port io_rden, input, 1 bit: read strobe from the scalar read I/O port wired to io_status.
REQ-009 SHALL have port io_status, output, WORD_WIDTH bits: status word for the scalar read I/O port.
REQ-010 SHALL have port out_valid, output, 1 bit: a head word is available downstream.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the head word.
REQ-012 SHALL have port out_data, output, WORD_WIDTH bits: the head word.

Function
REQ-013 SHALL push io_in when io_wren=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL pop the head when out_valid=1 and out_ready=1 (pop) at a rising edge.
REQ-015 SHALL assert out_valid exactly when count>0; a word written into an empty FIFO appears on out_data with out_valid=1 one cycle after the write edge.
REQ-016 SHALL drive out_data from the entry at the read pointer; out_data is don't-care when out_valid=0.
REQ-017 SHALL hold count (ADDR_WIDTH+1 bits, range 0..DEPTH) and update it as follows: push only adds 1, pop only subtracts 1, push and pop together leave it unchanged.
REQ-018 SHALL wrap the read and write pointers modulo DEPTH.
REQ-019 SHALL preserve FIFO order with no loss or duplication across pointer wrap-around.
REQ-020 SHALL drop a write with io_wren=1 while full and no pop, leaving the contents unchanged.
REQ-021 SHALL ignore io_wren=1 with out_ready=1 on an empty FIFO as a pop; it is a push only.
REQ-022 SHALL form io_status from registered state:
- bit0 = empty.
- bit1 = full.
- bit2 = overflow.
- bits[3+ADDR_WIDTH:3] = count.
- Remaining bits = 0.
REQ-023 SHALL keep io_status combinational from registers only, with no combinational path from io_wren, out_ready or io_rden.

Reset
REQ-024 SHALL, while reset=1 at an edge, clear both pointers, count and overflow.
REQ-025 SHALL, after reset, drive out_valid=0, io_status bit0=1, and all other io_status bits 0.
REQ-026 SHALL have reset take priority over any simultaneous push, pop or io_rden; words in flight mid-operation are discarded.
REQ-027 SHALL NOT reset the storage array.

Configuration
REQ-028 SHALL, with IO_WRITE_BUFFER_OVERFLOW_FLAG_EN defined, keep a sticky overflow bit.
- The bit sets on a dropped write (REQ-020).
- The bit clears on io_rden=1.
- When drop and io_rden coincide, set wins.
REQ-029 SHALL, without IO_WRITE_BUFFER_OVERFLOW_FLAG_EN, tie io_status bit2 to 0, ignore io_rden, and keep all other behaviour identical.

Structure
REQ-030 SHALL place the io_status bit-position constants (EMPTY_BIT, FULL_BIT, OVERFLOW_BIT, COUNT_LSB) in shared package io_buffer_pkg.
REQ-031 SHALL place the storage array (one write port, one asynchronous read port) in sub-module io_write_buffer_mem, with pointers, count and flags in io_write_buffer.

Verification
REQ-032 SHALL cover latency: after reset, io_wren=1 with io_in=0x123 for one cycle gives out_valid=1 and out_data=0x123 on the next cycle, and io_status count=1 with empty=0.
REQ-033 SHALL cover fill with drop: with out_ready=0, write 9 words 1..9 at DEPTH=8. Required: full=1, count=8; then out_ready=1 drains exactly 1..8 in order; overflow=1 only with the macro defined.
REQ-034 SHALL cover push and pop together while full: with the FIFO full and out_ready=1, io_wren=1 with data 0xAA keeps count at 8, and 0xAA drains last.
REQ-035 SHALL cover overflow clear: with overflow=1, io_rden=1 for one cycle gives overflow=0 next cycle; with io_rden and a dropped write in the same cycle, overflow stays 1.
REQ-036 SHALL cover wrap-around: 20 push-then-pop pairs with values 0..19 produce outputs 0..19 in order, with count never above 1.
REQ-037 SHALL cover reset mid-operation: with count=5, reset=1 together with io_wren=1 gives count=0, out_valid=0 and io_status=0x1 after the edge.

Source files
------------

// File: rtl/io_buffer_pkg.sv
// Shared bit positions of the io_status word returned on the scalar read I/O port.
package io_buffer_pkg;

    localparam int EMPTY_BIT    = 0;
    localparam int FULL_BIT     = 1;
    localparam int OVERFLOW_BIT = 2;
    localparam int COUNT_LSB    = 3;

endpackage

// File: rtl/io_write_buffer_mem.sv
// Storage array for io_write_buffer: one synchronous write port, one asynchronous read port.
module io_write_buffer_mem #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    // No reset: contents are only meaningful between the pointers.
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_write_buffer.sv
// Write FIFO between a scalar write I/O port and a valid/ready consumer, with a status word.
// Optional sticky overflow flag enabled by defining IO_WRITE_BUFFER_OVERFLOW_FLAG_EN.
module io_write_buffer
    import io_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] io_in,
    input  logic                  io_rden,
    output logic [WORD_WIDTH-1:0] io_status,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign out_valid = !empty;

    // Downstream handshake: the head word transfers on a rising edge where out_valid
    // and out_ready are both 1; out_valid never depends on out_ready.
    assign pop  = out_valid && out_ready;
    assign push = io_wren && (!full || pop);
    assign drop = io_wren && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef IO_WRITE_BUFFER_OVERFLOW_FLAG_EN
    // A drop in the same cycle as a status read must not be lost, so set beats clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (io_rden) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = io_rden | drop;
    assign overflow      = 1'b0;
`endif

    // Built only from registered state, so no strobe reaches the status word combinationally.
    always_comb begin
        io_status                          = '0;
        io_status[EMPTY_BIT]               = empty;
        io_status[FULL_BIT]                = full;
        io_status[OVERFLOW_BIT]            = overflow;
        io_status[COUNT_LSB +: ADDR_WIDTH+1] = count;
    end

    io_write_buffer_mem #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (io_in),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_io_write_buffer.sv
// Directed bench for io_write_buffer; overflow expectations follow IO_WRITE_BUFFER_OVERFLOW_FLAG_EN.
module tb_io_write_buffer;

    localparam int W = 36;

`ifdef IO_WRITE_BUFFER_OVERFLOW_FLAG_EN
    localparam logic [W-1:0] OVF = 36'h4;
`else
    localparam logic [W-1:0] OVF = 36'h0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         io_wren;
    logic [W-1:0] io_in;
    logic         io_rden;
    logic [W-1:0] io_status;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    io_write_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .io_wren   (io_wren),
        .io_in     (io_in),
        .io_rden   (io_rden),
        .io_status (io_status),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_wren   = 1'b0;
        io_rden   = 1'b0;
        out_ready = 1'b0;
        io_in     = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (io_status !== 36'h1) $display("FAIL reset_status: got %h want %h", io_status, 36'h1);
        else n_pass++;
    endtask

    task automatic test_latency();
        io_wren = 1'b1;
        io_in   = 36'h123;
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 36'h123)
            $display("FAIL latency_data: got valid=%b data=%h want 1 %h", out_valid, out_data, 36'h123);
        else n_pass++;
        n_checks++;
        if (io_status !== 36'h8) $display("FAIL latency_status: got %h want %h", io_status, 36'h8);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b0 || io_status !== 36'h1)
            $display("FAIL latency_drain: got valid=%b status=%h want 0 %h", out_valid, io_status, 36'h1);
        else n_pass++;
    endtask

    task automatic fill_eight();
        for (int i = 1; i <= 8; i++) begin
            io_wren = 1'b1;
            io_in   = W'(i);
            exp_q.push_back(W'(i));
            tick();
        end
        idle();
    endtask

    task automatic test_fill_drop();
        exp_q.delete();
        fill_eight();
        io_wren = 1'b1;
        io_in   = W'(9);
        tick();
        idle();
        n_checks++;
        if (io_status !== (36'h42 | OVF)) $display("FAIL fill_status: got %h want %h", io_status, 36'h42 | OVF);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v)
                $display("FAIL fill_drain[%0d]: got valid=%b data=%h want 1 %h", i, out_valid, out_data, exp_v);
            else n_pass++;
            tick();
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0 || io_status !== (36'h1 | OVF))
            $display("FAIL fill_empty: got valid=%b status=%h want 0 %h", out_valid, io_status, 36'h1 | OVF);
        else n_pass++;
    endtask

    task automatic test_overflow_clear();
        io_rden = 1'b1;
        tick();
        idle();
        n_checks++;
        if (io_status !== 36'h1) $display("FAIL ovf_clear: got %h want %h", io_status, 36'h1);
        else n_pass++;
        exp_q.delete();
        fill_eight();
        io_wren = 1'b1;
        io_rden = 1'b1;
        io_in   = 36'h55;
        tick();
        idle();
        n_checks++;
        if (io_status !== (36'h42 | OVF)) $display("FAIL ovf_set_wins: got %h want %h", io_status, 36'h42 | OVF);
        else n_pass++;
        io_rden = 1'b1;
        tick();
        idle();
        n_checks++;
        if (io_status !== 36'h42) $display("FAIL ovf_clear_full: got %h want %h", io_status, 36'h42);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b1;
        io_wren   = 1'b1;
        io_in     = 36'hAA;
        exp_v     = exp_q.pop_front();
        n_checks++;
        if (out_data !== exp_v) $display("FAIL pp_head: got %h want %h", out_data, exp_v);
        else n_pass++;
        exp_q.push_back(36'hAA);
        tick();
        io_wren = 1'b0;
        n_checks++;
        if (io_status !== 36'h42) $display("FAIL pp_count: got %h want %h", io_status, 36'h42);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v)
                $display("FAIL pp_drain[%0d]: got valid=%b data=%h want 1 %h", i, out_valid, out_data, exp_v);
            else n_pass++;
            tick();
        end
        idle();
        n_checks++;
        if (io_status !== 36'h1) $display("FAIL pp_empty: got %h want %h", io_status, 36'h1);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int v = 0; v < 20; v++) begin
            io_wren = 1'b1;
            io_in   = W'(v);
            tick();
            idle();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== W'(v) || io_status !== 36'h8)
                $display("FAIL wrap_push[%0d]: got valid=%b data=%h status=%h want 1 %h %h",
                         v, out_valid, out_data, io_status, W'(v), 36'h8);
            else n_pass++;
            out_ready = 1'b1;
            tick();
            idle();
            n_checks++;
            if (io_status !== 36'h1) $display("FAIL wrap_pop[%0d]: got %h want %h", v, io_status, 36'h1);
            else n_pass++;
        end
    endtask

    task automatic test_write_on_empty_with_ready();
        io_wren   = 1'b1;
        out_ready = 1'b1;
        io_rden   = 1'b1;
        io_in     = 36'h9_8765_4321;
        #1;
        n_checks++;
        if (io_status !== 36'h1) $display("FAIL status_comb: got %h want %h", io_status, 36'h1);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 36'h9_8765_4321 || io_status !== 36'h8)
            $display("FAIL empty_push_only: got valid=%b data=%h status=%h want 1 %h %h",
                     out_valid, out_data, io_status, 36'h9_8765_4321, 36'h8);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            io_wren = 1'b1;
            io_in   = W'(i + 40);
            tick();
        end
        idle();
        n_checks++;
        if (io_status !== 36'h28) $display("FAIL mid_count5: got %h want %h", io_status, 36'h28);
        else n_pass++;
        reset     = 1'b1;
        io_wren   = 1'b1;
        out_ready = 1'b1;
        io_in     = 36'h77;
        tick();
        reset = 1'b0;
        idle();
        n_checks++;
        if (out_valid !== 1'b0 || io_status !== 36'h1)
            $display("FAIL mid_reset: got valid=%b status=%h want 0 %h", out_valid, io_status, 36'h1);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || io_status !== 36'h1)
            $display("FAIL mid_reset_hold: got valid=%b status=%h want 0 %h", out_valid, io_status, 36'h1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_drop();
        test_overflow_clear();
        test_full_push_pop();
        test_wrap();
        test_write_on_empty_with_ready();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
